// File: rtl/mm_pkg.sv
// Shared constants for the matrix multiplier DRAM and its result reader.
// Holds the result region geometry and the reader state encoding.
package mm_pkg;

  localparam int MM_ADDR_W = 16;
  localparam int MM_DATA_W = 8;

  localparam logic [MM_ADDR_W-1:0] RESULT_BASE_ADDR = 16'h0024;
  localparam int                   RESULT_NUM_ELEM  = 18;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_WAIT_MM = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    RD_OUTPUT  = 3'd4,
    RD_DONE    = 3'd5
  } rd_state_t;

endpackage

// File: rtl/dram_result_reader.sv
// Walks NUM_ELEM result bytes from BASE_ADDR once the multiplier is idle; first o_valid 3 cycles after request,
// one element per 3 cycles. Each element is held on o_data/o_last until the consumer raises i_ready.
module dram_result_reader
  import mm_pkg::*;
#(
  parameter int                ADDR_W    = MM_ADDR_W,
  parameter int                DATA_W    = MM_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RESULT_BASE_ADDR),
  parameter int                NUM_ELEM  = RESULT_NUM_ELEM
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_read_req,
  input  logic              i_mm_busy,
  output logic              o_dram_read,
  output logic [ADDR_W-1:0] o_dram_addr,
  input  logic [DATA_W-1:0] i_dram_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int               CNT_W    = $clog2(NUM_ELEM + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEM - 1);

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             hsk;

  assign hsk = (state == RD_OUTPUT) && i_ready;

  // Strobes decode straight from state so an async reset clears them at once.
  assign o_dram_read = (state == RD_ISSUE);
  assign o_valid     = (state == RD_OUTPUT);
  assign o_done      = (state == RD_DONE);
  assign o_busy      = (state != RD_IDLE) && (state != RD_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:    if (i_read_req) state_nxt = RD_WAIT_MM;
      RD_WAIT_MM: if (!i_mm_busy) state_nxt = RD_ISSUE;
      RD_ISSUE:   state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = RD_OUTPUT;
      RD_OUTPUT:  if (i_ready) state_nxt = o_last ? RD_DONE : RD_ISSUE;
      RD_DONE:    state_nxt = RD_IDLE;
      default:    state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= RD_IDLE;
      cnt         <= '0;
      o_dram_addr <= BASE_ADDR;
      o_data      <= '0;
      o_last      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        RD_IDLE: begin
          if (i_read_req) begin
            cnt         <= '0;
            o_dram_addr <= BASE_ADDR;
          end
        end
        RD_CAPTURE: begin
          o_data <= i_dram_data;
          o_last <= (cnt == LAST_CNT);
        end
        RD_OUTPUT: begin
          if (hsk) begin
            o_last <= 1'b0;
            // Address wraps naturally modulo 2**ADDR_W.
            if (!o_last) begin
              cnt         <= cnt + CNT_W'(1);
              o_dram_addr <= o_dram_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_result_reader.sv
// Directed bench for dram_result_reader: default result region plus a wrapping and a single-element instance.
module tb_dram_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, mm_busy, ready;
  logic        rd, valid, last, busy, done;
  logic [15:0] addr;
  logic [7:0]  rdata, data;

  logic        req_w, rd_w, valid_w, last_w, busy_w, done_w;
  logic [15:0] addr_w;
  logic [7:0]  rdata_w, data_w;

  logic        req_s, rd_s, valid_s, last_s, busy_s, done_s;
  logic [15:0] addr_s;
  logic [7:0]  rdata_s, data_s;

  logic tie_rdy  = 1'b1;
  logic tie_idle = 1'b0;

  dram_result_reader dut (
    .i_clk(clk), .i_rst(rst), .i_read_req(req), .i_mm_busy(mm_busy),
    .o_dram_read(rd), .o_dram_addr(addr), .i_dram_data(rdata),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last),
    .o_busy(busy), .o_done(done)
  );

  dram_result_reader #(.BASE_ADDR(16'hFFFE), .NUM_ELEM(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_read_req(req_w), .i_mm_busy(tie_idle),
    .o_dram_read(rd_w), .o_dram_addr(addr_w), .i_dram_data(rdata_w),
    .o_data(data_w), .o_valid(valid_w), .i_ready(tie_rdy), .o_last(last_w),
    .o_busy(busy_w), .o_done(done_w)
  );

  dram_result_reader #(.BASE_ADDR(16'h0030), .NUM_ELEM(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_read_req(req_s), .i_mm_busy(tie_idle),
    .o_dram_read(rd_s), .o_dram_addr(addr_s), .i_dram_data(rdata_s),
    .o_data(data_s), .o_valid(valid_s), .i_ready(tie_rdy), .o_last(last_s),
    .o_busy(busy_s), .o_done(done_s)
  );

  // DRAM: read data appears one cycle after the strobe
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (rd)   rdata   <= mem[addr];
    if (rd_w) rdata_w <= mem[addr_w];
    if (rd_s) rdata_s <= mem[addr_s];
  end

  logic [7:0] exp_tab [18] = '{8'h7C, 8'h2D, 8'hC2, 8'h49, 8'hC4, 8'h31, 8'h44, 8'h43, 8'hCB,
                               8'h58, 8'h69, 8'h5F, 8'hDC, 8'h7D, 8'h1F, 8'hB1, 8'hBF, 8'hC7};
  logic [15:0] w_addr_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [7:0]  w_data_exp [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: the only writers of the observation queues
  logic [7:0]  q_data[$];
  logic        q_last[$];
  logic [15:0] q_raddr[$];
  time         q_vrise[$];
  time         t_done;
  int          n_done  = 0;
  int          collide = 0;
  logic        valid_prev = 1'b0;

  logic [7:0]  qw_data[$];
  logic        qw_last[$];
  logic [15:0] qw_raddr[$];
  int          nw_done = 0;
  logic [7:0]  qs_data[$];
  logic        qs_last[$];
  int          ns_reads = 0;
  int          ns_done  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd) q_raddr.push_back(addr);
      if (valid && ready) begin
        q_data.push_back(data);
        q_last.push_back(last);
      end
      if (valid && !valid_prev) q_vrise.push_back($time);
      if (done) begin
        n_done++;
        t_done = $time;
      end
      if (rd && valid) collide++;
      valid_prev = valid;
      if (rd_w) qw_raddr.push_back(addr_w);
      if (valid_w) begin
        qw_data.push_back(data_w);
        qw_last.push_back(last_w);
      end
      if (done_w) nw_done++;
      if (rd_s) ns_reads++;
      if (valid_s) begin
        qs_data.push_back(data_s);
        qs_last.push_back(last_s);
      end
      if (done_s) ns_done++;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic pulse(output time t_req);
    @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk);
    t_req = $time;
    #1 req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_done > base) break;
    end
    #1 check({tag, "_done_seen"}, int'(n_done > base), 1);
  endtask

  task automatic check_run(input string tag, input int bd, input int br);
    check({tag, "_beats"}, q_data.size() - bd, 18);
    check({tag, "_reads"}, q_raddr.size() - br, 18);
    for (int i = 0; i < 18; i++) begin
      if (bd + i < q_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), int'(q_data[bd+i]), int'(exp_tab[i]));
        check($sformatf("%s_last%0d", tag, i), int'(q_last[bd+i]), int'(i == 17));
      end
      if (br + i < q_raddr.size())
        check($sformatf("%s_addr%0d", tag, i), int'(q_raddr[br+i]), 16'h0024 + i);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    int'(rd),    0);
    check({tag, "_addr"},  int'(addr),  16'h0024);
    check({tag, "_data"},  int'(data),  0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_last"},  int'(last),  0);
    check({tag, "_busy"},  int'(busy),  0);
    check({tag, "_done"},  int'(done),  0);
  endtask

  initial begin
    time t_req;
    int  bd, br, bv, nd, hold;

    rst = 1'b1; req = 1'b0; mm_busy = 1'b0; ready = 1'b1; req_w = 1'b0; req_s = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 18; i++) mem[16'h0024 + i] = exp_tab[i];
    mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hA2; mem[16'h0000] = 8'hA3; mem[16'h0001] = 8'hA4;

    #22;
    check_reset_outputs("rst");
    check("rst_addr_w", int'(addr_w), 16'hFFFE);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: plain readout, latency and total length
    bd = q_data.size(); br = q_raddr.size(); bv = q_vrise.size(); nd = n_done;
    pulse(t_req);
    wait_done("t1", nd, 100);
    if (bv < q_vrise.size())
      check("t1_first_valid_edges", int'((q_vrise[bv] - t_req - 5) / 10), 3);
    // edges from the request edge to the edge that samples o_done
    check("t1_done_edges", int'((t_done - t_req + 5) / 10), 56);
    check("t1_done_count", n_done - nd, 1);
    check_run("t1", bd, br);

    // 2: multiplier busy holds off the first read
    repeat (3) @(posedge clk);
    #1 mm_busy = 1'b1;
    bd = q_data.size(); br = q_raddr.size(); nd = n_done;
    pulse(t_req);
    repeat (100) @(posedge clk);
    #1;
    check("t2_no_read_while_mm_busy", q_raddr.size() - br, 0);
    check("t2_busy_while_waiting", int'(busy), 1);
    mm_busy = 1'b0;
    wait_done("t2", nd, 100);
    if (br < q_raddr.size()) check("t2_first_addr", int'(q_raddr[br]), 16'h0024);
    check_run("t2", bd, br);

    // 3: random backpressure with a long stall on beat 5
    repeat (3) @(posedge clk);
    bd = q_data.size(); br = q_raddr.size(); nd = n_done; hold = 0;
    pulse(t_req);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (n_done > nd) break;
      if (valid && (q_data.size() - bd == 4) && hold < 10) begin
        ready = 1'b0;
        hold++;
        check("t3_hold_data", int'(data), 8'hC4);
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
    end
    ready = 1'b1;
    check("t3_done_seen", int'(n_done > nd), 1);
    check("t3_stall_cycles", hold, 10);
    check_run("t3", bd, br);

    // 4: reset during beat 9 aborts, next request restarts from the base
    repeat (3) @(posedge clk);
    bd = q_data.size(); nd = n_done;
    pulse(t_req);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (valid && (q_data.size() - bd == 8)) break;
    end
    check("t4_reached_beat9", q_data.size() - bd, 8);
    rst = 1'b1;
    #1 check_reset_outputs("t4_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("t4_no_done_after_abort", n_done - nd, 0);
    bd = q_data.size(); br = q_raddr.size(); nd = n_done;
    pulse(t_req);
    wait_done("t4", nd, 100);
    check_run("t4", bd, br);

    // 5: extra requests while busy are dropped
    repeat (3) @(posedge clk);
    bd = q_data.size(); br = q_raddr.size(); nd = n_done;
    pulse(t_req);
    repeat (4) @(posedge clk);
    pulse(t_req);
    repeat (14) @(posedge clk);
    pulse(t_req);
    repeat (16) @(posedge clk);
    pulse(t_req);
    wait_done("t5", nd, 100);
    repeat (20) @(posedge clk);
    check("t5_done_count", n_done - nd, 1);
    check_run("t5", bd, br);

    // 6: address wrap and single-element instances
    @(posedge clk);
    #1 begin req_w = 1'b1; req_s = 1'b1; end
    @(posedge clk);
    #1 begin req_w = 1'b0; req_s = 1'b0; end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (nw_done > 0 && ns_done > 0) break;
    end
    #1;
    check("t6_wrap_reads", qw_raddr.size(), 4);
    check("t6_wrap_beats", qw_data.size(), 4);
    check("t6_wrap_done", nw_done, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < qw_raddr.size())
        check($sformatf("t6_wrap_addr%0d", i), int'(qw_raddr[i]), int'(w_addr_exp[i]));
      if (i < qw_data.size()) begin
        check($sformatf("t6_wrap_data%0d", i), int'(qw_data[i]), int'(w_data_exp[i]));
        check($sformatf("t6_wrap_last%0d", i), int'(qw_last[i]), int'(i == 3));
      end
    end
    check("t6_single_reads", ns_reads, 1);
    check("t6_single_beats", qs_data.size(), 1);
    check("t6_single_done", ns_done, 1);
    if (qs_data.size() > 0) begin
      check("t6_single_data", int'(qs_data[0]), 8'hDC);
      check("t6_single_last", int'(qs_last[0]), 1);
    end

    check("no_read_valid_overlap", collide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
